// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared opcode constants and FSM state encoding for the ALU scheduler
package alu_sched_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_SHR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - registered W-bit mini-ALU; result only updates when en is high
module alu_core
  import alu_sched_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res
);

  logic [W-1:0] w_res_next;
  logic [W-1:0] r_res;

  always_comb begin
    w_res_next = '0;
    case (op)
      OP_ADD:  w_res_next = a + b;
      OP_SUB:  w_res_next = a + ~b + W'(1);
      OP_AND:  w_res_next = a & b;
      default: w_res_next = a >> 1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res <= '0;
    end else if (en) begin
      r_res <= w_res_next;
    end
  end

  assign res = r_res;

endmodule

// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - round-robin arbiter sharing one registered ALU among N requesters
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int N    = 2,
  parameter int W    = 3,
  parameter int IDW  = 1,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [2*N-1:0]  req_op,
  input  logic [W*N-1:0]  req_a,
  input  logic [W*N-1:0]  req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IDW-1:0]  rsp_id,
  output logic [W-1:0]    rsp_data,
  output logic [CNTW-1:0] done_cnt,
  output logic            busy
);

  localparam logic [IDW:0] NW = (IDW + 1)'(N);

  state_t          r_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_gnt;
  logic [IDW-1:0]  r_rsp_id;
  logic [1:0]      r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_rsp_valid;
  logic [CNTW-1:0] r_done_cnt;

  logic            w_found;
  logic [IDW-1:0]  w_grant;
  logic [IDW:0]    w_sum;
  logic            w_alu_en;
  logic [W-1:0]    w_res;

  // Walk from the highest offset down so the closest valid requester to rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_sum   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (IDW + 1)'(k);
      if (w_sum >= NW) w_sum = w_sum - NW;
      if (req_valid[w_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && r_state == IDLE && w_found) req_ready[w_grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_gnt       <= '0;
      r_rsp_id    <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= 1'b0;
      r_done_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_op     <= req_op[2*int'(w_grant) +: 2];
            r_a      <= req_a[W*int'(w_grant) +: W];
            r_b      <= req_b[W*int'(w_grant) +: W];
            r_gnt    <= w_grant;
            r_rr_ptr <= (w_grant == IDW'(N - 1)) ? '0 : w_grant + IDW'(1);
            r_state  <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_gnt;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_done_cnt  <= r_done_cnt + CNTW'(1);
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_alu_en = (r_state == EXEC);

  alu_core #(.W(W)) u_alu (
    .clk (clk),
    .rst (rst),
    .en  (w_alu_en),
    .op  (r_op),
    .a   (r_a),
    .b   (r_b),
    .res (w_res)
  );

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = w_res;
  assign done_cnt  = r_done_cnt;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb/tb_alu_rr_scheduler.sv - directed and randomized checks of alu_rr_scheduler against a behavioural model
module tb_alu_rr_scheduler;

  localparam int N    = 2;
  localparam int W    = 3;
  localparam int IDW  = 1;
  localparam int CNTW = 8;
  localparam int M    = 1 << W;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [2*N-1:0]  req_op;
  logic [W*N-1:0]  req_a;
  logic [W*N-1:0]  req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [W-1:0]    rsp_data;
  logic [CNTW-1:0] done_cnt;
  logic            busy;

  alu_rr_scheduler #(.N(N), .W(W), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .done_cnt  (done_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr   = 0;
  int m_done  = 0;
  int t_op [N];
  int t_a  [N];
  int t_b  [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_alu(input int op, input int a, input int b);
    case (op)
      0:       return (a + b) % M;
      1:       return (a - b + M) % M;
      2:       return a & b;
      default: return a / 2;
    endcase
  endfunction

  function automatic int ref_grant(input logic [N-1:0] mask, input int p);
    for (int k = 0; k < N; k++) begin
      if (mask[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic drive_in();
    for (int i = 0; i < N; i++) begin
      req_op[2*i +: 2] = 2'(t_op[i]);
      req_a[W*i +: W]  = W'(t_a[i]);
      req_b[W*i +: W]  = W'(t_b[i]);
    end
  endtask

  task automatic rand_in();
    for (int i = 0; i < N; i++) begin
      t_op[i] = int'($urandom_range(0, 3));
      t_a[i]  = int'($urandom_range(0, M - 1));
      t_b[i]  = int'($urandom_range(0, M - 1));
    end
    drive_in();
  endtask

  // Entered in an IDLE cycle; leaves one cycle after the response handshake with req_valid cleared.
  task automatic run_op(input logic [N-1:0] mask, input int stall, input int fixed);
    int g;
    int r;
    req_valid = mask;
    drive_in();
    #1;
    g = ref_grant(mask, m_ptr);
    r = ref_alu(t_op[g], t_a[g], t_b[g]);
    chk("grant", 32'(req_ready), 32'(1 << g));
    chk("idle_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rand_in();
    chk("exec_busy", 32'(busy), 1);
    chk("exec_rsp_valid", 32'(rsp_valid), 0);
    chk("exec_req_ready", 32'(req_ready), 0);
    rsp_ready = (stall == 0);
    @(posedge clk); #1;
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_id", 32'(rsp_id), 32'(g));
    chk("rsp_data", 32'(rsp_data), 32'(r));
    if (fixed >= 0) chk("rsp_data_directed", 32'(rsp_data), 32'(fixed));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_id", 32'(rsp_id), 32'(g));
      chk("hold_data", 32'(rsp_data), 32'(r));
      chk("hold_req_ready", 32'(req_ready), 0);
      rsp_ready = (s == stall - 1);
    end
    @(posedge clk); #1;
    m_done = (m_done + 1) % (1 << CNTW);
    m_ptr  = (g + 1) % N;
    chk("post_rsp_valid", 32'(rsp_valid), 0);
    chk("post_done_cnt", 32'(done_cnt), 32'(m_done));
    chk("post_rsp_id", 32'(rsp_id), 32'(g));
    chk("post_rsp_data", 32'(rsp_data), 32'(r));
    chk("post_busy", 32'(busy), 0);
    req_valid = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++) begin
      t_op[i] = 0; t_a[i] = 0; t_b[i] = 0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_done_cnt", 32'(done_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    rst = 1'b0;
    #1;
    chk("first_grant", 32'(req_ready), 32'h1);

    // Contention straight out of reset: grants alternate starting at requester 0.
    for (int k = 0; k < 4; k++) begin
      rand_in();
      run_op(2'b11, 0, -1);
    end

    // Directed operations on requester 0.
    t_op[0] = 0; t_a[0] = 3; t_b[0] = 6; run_op(2'b01, 0, 1);
    t_op[0] = 1; t_a[0] = 2; t_b[0] = 5; run_op(2'b01, 0, 5);
    t_op[0] = 2; t_a[0] = 6; t_b[0] = 3; run_op(2'b01, 0, 2);
    t_op[0] = 3; t_a[0] = 7; t_b[0] = 0; run_op(2'b01, 0, 3);
    chk("done_after_directed", 32'(done_cnt), 8);

    // Backpressure with both requesters pending.
    rand_in();
    run_op(2'b11, 4, -1);

    // Reset while the operation is in EXEC.
    rand_in();
    req_valid = 2'b10;
    #1;
    chk("midrst_grant", 32'(req_ready), 32'(1 << ref_grant(2'b10, m_ptr)));
    @(posedge clk); #1;
    req_valid = '0;
    chk("midrst_exec_busy", 32'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_done_cnt", 32'(done_cnt), 0);
    rst    = 1'b0;
    m_ptr  = 0;
    m_done = 0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("midrst_no_rsp", 32'(rsp_valid), 0);
    end

    // 256 randomized operations wrap the counter back to zero.
    for (int k = 0; k < 256; k++) begin
      rand_in();
      run_op(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(0, 2)), -1);
    end
    chk("wrap_zero", 32'(done_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
